// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types for the register-file hazard controller.
//   ADDR_W     : register address width (16 registers).
//   fwd_sel_e  : EX-stage operand source select.
//   slot_t     : one in-flight producer {valid, rd, is_load}.
//   fwd_pick() : priority pick of the forward select for one source operand.
// -----------------------------------------------------------------------------
package hazard_pkg;

    localparam int ADDR_W = 4;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,  // register file
        FWD_EXMEM = 2'b01,  // EX/MEM pipeline register
        FWD_MEMWB = 2'b10   // MEM/WB pipeline register
    } fwd_sel_e;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic              is_load;
    } slot_t;

    // The youngest producer (EX) wins over the older one (MEM).
    function automatic fwd_sel_e fwd_pick(input logic ex_hit, input logic mem_hit);
        fwd_sel_e sel;
        sel = FWD_RF;
        if (ex_hit) begin
            sel = FWD_EXMEM;
        end else if (mem_hit) begin
            sel = FWD_MEMWB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_addr_match.sv
// -----------------------------------------------------------------------------
// hazard_addr_match
// Qualified register address comparator: a source matches an in-flight
// producer only when the source is actually read, the producer slot is valid
// and the two addresses are equal.
// Ports:
//   used_i  : source operand is read by the decode instruction
//   valid_i : producer slot holds a register-writing instruction
//   a_i     : source register address
//   b_i     : producer destination address
//   match_o : qualified match
// -----------------------------------------------------------------------------
module hazard_addr_match #(
    parameter int W = 4
) (
    input  logic         used_i,
    input  logic         valid_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         match_o
);

    assign match_o = used_i & valid_i & (a_i == b_i);

endmodule

// File: rtl/reg_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// reg_hazard_ctrl
// Pipeline hazard controller for a 16-entry register file. Tracks the
// destinations of instructions in EX and MEM and decides whether the decode
// instruction issues, stalls, or gets its operands forwarded.
//
// Build option: define HAZARD_FWD_EN to enable operand forwarding; only a
// load in EX then stalls. Without it, any EX/MEM match stalls and the forward
// selects are tied to the register file.
//
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   id_valid                   : decode holds an instruction
//   id_rs1/id_rs2, *_used      : source addresses and read qualifiers
//   id_rd, id_rd_wr            : destination address and write enable
//   id_is_load                 : result only available after MEM
//   flush                      : kill the decode instruction
//   stall                      : (comb) hold PC/IF/ID, bubble into EX
//   issue                      : (comb) instruction enters EX this cycle
//   fwd_a, fwd_b               : (reg) operand selects while in EX
//   stall_count                : (reg) saturating count of stall cycles
//
// The WB slot is not stored: the register file writes before it reads, so a
// producer in WB can never cause a stall or a forward.
// ADDR_W must equal hazard_pkg::ADDR_W because slot_t is sized from it.
// -----------------------------------------------------------------------------
module reg_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int ADDR_W = hazard_pkg::ADDR_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic [ADDR_W-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_rd_wr,
    input  logic              id_is_load,
    input  logic              flush,
    output logic              stall,
    output logic              issue,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_count
);

    // EX slot keeps is_load for load-use detection; MEM only needs valid/rd.
    slot_t             ex_q, ex_d;
    logic              mem_valid_q;
    logic [ADDR_W-1:0] mem_rd_q;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;

    logic [ADDR_W-1:0] src_addr [2];
    logic              src_used [2];
    logic              ex_hit   [2];
    logic              mem_hit  [2];
    logic              load_use;
    logic              hazard;

    assign src_addr[0] = id_rs1;
    assign src_addr[1] = id_rs2;
    assign src_used[0] = id_rs1_used;
    assign src_used[1] = id_rs2_used;

    // Four comparators: {rs1, rs2} x {EX, MEM}.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            hazard_addr_match #(.W(ADDR_W)) u_ex_match (
                .used_i  (src_used[gi]),
                .valid_i (ex_q.valid),
                .a_i     (src_addr[gi]),
                .b_i     (ex_q.rd),
                .match_o (ex_hit[gi])
            );
            hazard_addr_match #(.W(ADDR_W)) u_mem_match (
                .used_i  (src_used[gi]),
                .valid_i (mem_valid_q),
                .a_i     (src_addr[gi]),
                .b_i     (mem_rd_q),
                .match_o (mem_hit[gi])
            );
        end
    endgenerate

    always_comb begin
        load_use = (ex_hit[0] | ex_hit[1]) & ex_q.is_load;
`ifdef HAZARD_FWD_EN
        hazard = load_use;
`else
        // load_use is a subset of the EX match; it is kept so both builds
        // share the same terms.
        hazard = load_use | ex_hit[0] | ex_hit[1] | mem_hit[0] | mem_hit[1];
`endif
        // flush dominates: a killed instruction neither stalls nor issues.
        stall = id_valid & ~flush & hazard;
        issue = id_valid & ~stall & ~flush;
    end

    always_comb begin
        ex_d.valid   = issue & id_rd_wr;
        ex_d.rd      = id_rd;
        ex_d.is_load = id_is_load;

        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q          <= '0;
            mem_valid_q   <= 1'b0;
            mem_rd_q      <= '0;
            stall_count_q <= '0;
        end else begin
            ex_q          <= ex_d;
            mem_valid_q   <= ex_q.valid;
            mem_rd_q      <= ex_q.rd;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

`ifdef HAZARD_FWD_EN
    fwd_sel_e fwd_q [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    fwd_q[gi] <= FWD_RF;
                end else begin
                    fwd_q[gi] <= issue ? fwd_pick(ex_hit[gi], mem_hit[gi]) : FWD_RF;
                end
            end
        end
    endgenerate

    assign fwd_a = fwd_q[0];
    assign fwd_b = fwd_q[1];
`else
    assign fwd_a = FWD_RF;
    assign fwd_b = FWD_RF;
`endif

endmodule
